// File: rtl/video_timing_pkg.sv
// video_timing_pkg: default 15 kHz raster timing and the rgb444 pixel type,
// shared by the shifter and the scandoubler-side blocks.
package video_timing_pkg;
   localparam int CLK_DIV_DEF      = 4;
   localparam int H_TOTAL_DEF      = 342;
   localparam int H_ACTIVE_DEF     = 256;
   localparam int H_SYNC_START_DEF = 280;
   localparam int H_SYNC_LEN_DEF   = 26;
   localparam int V_TOTAL_DEF      = 262;
   localparam int V_ACTIVE_DEF     = 192;
   localparam int V_SYNC_START_DEF = 224;
   localparam int V_SYNC_LEN_DEF   = 3;
   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;
endpackage

// File: rtl/pix_fifo.sv
// pix_fifo: 4-entry rgb444 prefetch FIFO; flush wins over push, push+pop keeps count.
module pix_fifo
   import video_timing_pkg::*;
(
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic       flush,
   input  rgb444_t    din,
   output rgb444_t    dout,
   output logic       full,
   output logic       empty,
   output logic [2:0] count
);
   rgb444_t    mem_q [4];
   rgb444_t    mem_d [4];
   logic [1:0] wr_q, wr_d, rd_q, rd_d;
   logic [2:0] cnt_q, cnt_d;
   logic       do_push, do_pop;
   always_comb begin
      full    = cnt_q == 3'd4;
      empty   = cnt_q == 3'd0;
      count   = cnt_q;
      dout    = mem_q[rd_q];
      do_push = push && !full && !flush;
      do_pop  = pop && !empty && !flush;
      mem_d   = mem_q;
      if (do_push) mem_d[wr_q] = din;
      wr_d    = flush ? 2'd0 : wr_q + 2'(do_push);
      rd_d    = flush ? 2'd0 : rd_q + 2'(do_pop);
      cnt_d   = flush ? 3'd0 : cnt_q + 3'(do_push) - 3'(do_pop);
   end
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
   always_ff @(posedge clk_sys) mem_q <= mem_d;
endmodule

// File: rtl/video_shifter.sv
// video_shifter: 15 kHz raster generator; active pixels are pulled from an
// upstream stream through a 4-entry prefetch FIFO flushed once per frame.
module video_shifter
   import video_timing_pkg::*;
#(
   parameter int CLK_DIV      = CLK_DIV_DEF,
   parameter int H_TOTAL      = H_TOTAL_DEF,
   parameter int H_ACTIVE     = H_ACTIVE_DEF,
   parameter int H_SYNC_START = H_SYNC_START_DEF,
   parameter int H_SYNC_LEN   = H_SYNC_LEN_DEF,
   parameter int V_TOTAL      = V_TOTAL_DEF,
   parameter int V_ACTIVE     = V_ACTIVE_DEF,
   parameter int V_SYNC_START = V_SYNC_START_DEF,
   parameter int V_SYNC_LEN   = V_SYNC_LEN_DEF
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [11:0] pix_data,
   input  logic        pix_valid,
   output logic        pix_ready,
   output logic        ce_pix,
   output logic [8:0]  hcnt,
   output logic [8:0]  vcnt,
   output logic        hs_out,
   output logic        vs_out,
   output logic        de_out,
   output logic [3:0]  r_out,
   output logic [3:0]  g_out,
   output logic [3:0]  b_out,
   output logic        frame_start,
   output logic        underrun
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   logic [DW-1:0] div_q, div_d;
   logic [8:0]    hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d, und_q, und_d;
   rgb444_t       rgb_q, rgb_d, fifo_dout;
   logic          div_last, h_last, v_last, active, flush, push, pop, full, empty;
   logic [2:0]    fifo_count;
   pix_fifo u_fifo (
      .clk_sys (clk_sys),
      .reset   (reset),
      .push    (push),
      .pop     (pop),
      .flush   (flush),
      .din     (rgb444_t'(pix_data)),
      .dout    (fifo_dout),
      .full    (full),
      .empty   (empty),
      .count   (fifo_count)
   );
   always_comb begin
      div_last    = div_q == DW'(CLK_DIV - 1);
      ce_pix      = div_last && !reset;
      h_last      = hcnt_q == 9'(H_TOTAL - 1);
      v_last      = vcnt_q == 9'(V_TOTAL - 1);
      active      = hcnt_q < 9'(H_ACTIVE) && vcnt_q < 9'(V_ACTIVE);
      flush       = ce_pix && h_last && v_last;
      frame_start = flush;
      pix_ready   = !full && !flush && !reset;
      push        = pix_valid && pix_ready;
      pop         = ce_pix && active && !empty;
      div_d       = div_last ? '0 : div_q + 1'b1;
      hcnt_d      = ce_pix ? (h_last ? 9'd0 : hcnt_q + 9'd1) : hcnt_q;
      vcnt_d      = (ce_pix && h_last) ? (v_last ? 9'd0 : vcnt_q + 9'd1) : vcnt_q;
      hs_d        = ce_pix ? !(hcnt_q >= 9'(H_SYNC_START) && hcnt_q < 9'(H_SYNC_START + H_SYNC_LEN)) : hs_q;
      // VS only moves with the HS falling edge so the doubler sees both edges together
      vs_d        = (ce_pix && hcnt_q == 9'(H_SYNC_START))
                    ? !(vcnt_q >= 9'(V_SYNC_START) && vcnt_q < 9'(V_SYNC_START + V_SYNC_LEN)) : vs_q;
      de_d        = ce_pix ? active : de_q;
      rgb_d       = ce_pix ? (pop ? fifo_dout : '0) : rgb_q;
      und_d       = ce_pix && active && fifo_count == 3'd0;
   end
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         div_q  <= '0;
         hcnt_q <= '0;
         vcnt_q <= '0;
         hs_q   <= 1'b1;
         vs_q   <= 1'b1;
         de_q   <= 1'b0;
         rgb_q  <= '0;
         und_q  <= 1'b0;
      end else begin
         div_q  <= div_d;
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
         hs_q   <= hs_d;
         vs_q   <= vs_d;
         de_q   <= de_d;
         rgb_q  <= rgb_d;
         und_q  <= und_d;
      end
   end
   assign hcnt     = hcnt_q;
   assign vcnt     = vcnt_q;
   assign hs_out   = hs_q;
   assign vs_out   = vs_q;
   assign de_out   = de_q;
   assign r_out    = rgb_q.r;
   assign g_out    = rgb_q.g;
   assign b_out    = rgb_q.b;
   assign underrun = und_q;
endmodule

// File: tb/tb_video_shifter.sv
// tb_video_shifter: small-raster bench; a pixel-index model with a queue FIFO
// predicts every output each cycle, plus literal frame/line checks.
module tb_video_shifter;
   localparam int CD = 4, HT = 20, HA = 8, HSS = 12, HSL = 3;
   localparam int VT = 10, VA = 6, VSS = 7, VSL = 2;
   localparam int FRAME = HT * VT * CD;
   logic        clk_sys = 1'b0, reset = 1'b1, pix_valid = 1'b0;
   logic [11:0] pix_data = '0;
   logic        pix_ready, ce_pix, hs_out, vs_out, de_out, frame_start, underrun;
   logic [8:0]  hcnt, vcnt;
   logic [3:0]  r_out, g_out, b_out;
   int vectors = 0, errors = 0, cyc = 0;
   int m_t = 0, m_p = 0, q[$];
   logic [11:0] e_rgb = '0;
   bit e_de = 0, e_und = 0, started = 0, lit_pend = 0;
   int mode = 0, hold_cnt = 0, up_idx = 0, exp_und = HA * VA;
   bit hold_arm = 0, last_fs = 0, prev_fs = 0, prev_rst = 0;
   int de_cnt = 0, und_cnt = 0, fs_cyc = 0, hs_fall = 0, vs_fall = 0;
   bit frame_ok = 0, fs_seen = 0, hs_seen = 0, vs_seen = 0, hs_prev = 1, vs_prev = 1;

   video_shifter #(
      .CLK_DIV(CD), .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
      .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL)
   ) dut (
      .clk_sys(clk_sys), .reset(reset), .pix_data(pix_data), .pix_valid(pix_valid),
      .pix_ready(pix_ready), .ce_pix(ce_pix), .hcnt(hcnt), .vcnt(vcnt),
      .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out),
      .r_out(r_out), .g_out(g_out), .b_out(b_out),
      .frame_start(frame_start), .underrun(underrun)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(string name, int act, int exp);
      vectors++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // HS of the most recently output pixel (p pixels have elapsed since reset)
   function automatic bit exp_hs(int p);
      int hl;
      if (p == 0) return 1'b1;
      hl = (p - 1) % HT;
      return !(hl >= HSS && hl < HSS + HSL);
   endfunction

   // VS is the sync state of the latest line whose HS edge has already passed
   function automatic bit exp_vs(int p);
      int l;
      if (p == 0) return 1'b1;
      l = (p - 1) / HT - ((((p - 1) % HT) < HSS) ? 1 : 0);
      if (l < 0) return 1'b1;
      l = l % VT;
      return !(l >= VSS && l < VSS + VSL);
   endfunction

   function automatic bit m_ce();
      return !reset && (m_t % CD == CD - 1);
   endfunction

   function automatic bit m_flush();
      return m_ce() && (m_p % HT == HT - 1) && ((m_p / HT) % VT == VT - 1);
   endfunction

   task automatic check();
      chk("ce_pix", int'(ce_pix), int'(m_ce()));
      chk("pix_ready", int'(pix_ready), int'(!reset && q.size() < 4 && !m_flush()));
      chk("frame_start", int'(frame_start), int'(m_flush()));
      chk("hcnt", int'(hcnt), m_p % HT);
      chk("vcnt", int'(vcnt), (m_p / HT) % VT);
      chk("hs_out", int'(hs_out), int'(exp_hs(m_p)));
      chk("vs_out", int'(vs_out), int'(exp_vs(m_p)));
      chk("de_out", int'(de_out), int'(e_de));
      chk("rgb", int'({r_out, g_out, b_out}), int'(e_rgb));
      chk("underrun", int'(underrun), int'(e_und));
   endtask

   task automatic model_update();
      bit ce, fl, act, psh;
      int h, v;
      ce  = m_ce();
      fl  = m_flush();
      h   = m_p % HT;
      v   = (m_p / HT) % VT;
      act = h < HA && v < VA;
      psh = pix_valid && !reset && q.size() < 4 && !fl;
      if (reset) begin
         m_t = 0; m_p = 0; q.delete();
         e_de = 0; e_rgb = '0; e_und = 0; started = 1;
         return;
      end
      e_und = 0;
      if (ce) begin
         e_de  = act;
         e_rgb = '0;
         if (act && q.size() > 0) e_rgb = 12'(q.pop_front());
         else e_und = act;
         lit_pend = mode == 1 && h == 3 && v == 2;
         m_p++;
      end
      if (fl) q.delete();
      else if (psh) q.push_back(int'(pix_data));
      m_t++;
   endtask

   task automatic step(bit rst);
      bit acc;
      @(negedge clk_sys);
      reset = rst;
      if (mode == 1 && hold_arm && !rst && m_t % CD == 0 && m_p % HT == 0 && (m_p / HT) % VT == 2) begin
         hold_cnt = 28;
         hold_arm = 0;
         exp_und  = 3;
      end
      pix_valid = (mode == 2) ? ($urandom_range(0, 3) != 0) : (mode == 1 && hold_cnt == 0);
      pix_data  = (mode == 2) ? 12'($urandom) : 12'(up_idx);
      if (hold_cnt > 0) hold_cnt--;
      #1;
      if (started) begin
         check();
         if (lit_pend) chk("rgb_at_x3_y2", int'({r_out, g_out, b_out}), 'h013);
         lit_pend = 0;
         if (rst) chk("ready_in_reset", int'(pix_ready), 0);
         if (prev_rst && !rst) begin
            chk("hcnt_after_reset", int'(hcnt), 0);
            chk("vcnt_after_reset", int'(vcnt), 0);
            chk("hs_after_reset", int'(hs_out), 1);
            chk("de_after_reset", int'(de_out), 0);
            chk("rgb_after_reset", int'({r_out, g_out, b_out}), 0);
            chk("ready_after_reset", int'(pix_ready), 1);
         end
         if (prev_fs && !rst) chk("ready_after_flush", int'(pix_ready), 1);
         if (rst) begin
            de_cnt = 0; und_cnt = 0; frame_ok = 1; fs_seen = 0; hs_seen = 0; vs_seen = 0;
            exp_und = (mode == 0) ? HA * VA : 0;
         end else begin
            if (ce_pix && de_out) de_cnt++;
            und_cnt += int'(underrun);
            if (hs_prev && !hs_out) begin
               if (hs_seen) chk("hs_period", cyc - hs_fall, HT * CD);
               hs_seen = 1; hs_fall = cyc;
            end
            if (!hs_prev && hs_out && hs_seen) chk("hs_low_len", cyc - hs_fall, HSL * CD);
            if (vs_prev && !vs_out) begin
               if (vs_seen) chk("vs_period", cyc - vs_fall, FRAME);
               if (hs_seen) chk("vs_with_hs", cyc - hs_fall, 0);
               vs_seen = 1; vs_fall = cyc;
            end
            if (!vs_prev && vs_out && vs_seen) chk("vs_low_len", cyc - vs_fall, VSL * HT * CD);
            if (frame_start) begin
               chk("ready_in_flush", int'(pix_ready), 0);
               if (frame_ok) begin
                  chk("frame_de_count", de_cnt, HA * VA);
                  if (mode != 2) chk("frame_underruns", und_cnt, exp_und);
               end
               if (fs_seen) chk("frame_period", cyc - fs_cyc, FRAME);
               fs_seen = 1; fs_cyc = cyc; de_cnt = 0; und_cnt = 0; frame_ok = 1;
               exp_und = (mode == 0) ? HA * VA : 0;
            end
         end
      end
      acc      = pix_valid && pix_ready;
      last_fs  = frame_start;
      prev_fs  = frame_start;
      prev_rst = rst;
      hs_prev  = hs_out;
      vs_prev  = vs_out;
      @(posedge clk_sys);
      model_update();
      up_idx = (rst || last_fs) ? 0 : (acc ? up_idx + 1 : up_idx);
      cyc++;
   endtask

   task automatic run_until_fs();
      int n;
      n = 0;
      do begin
         step(1'b0);
         n++;
      end while (!last_fs && n < 2 * FRAME);
      chk("frame_start_seen", int'(last_fs), 1);
   endtask

   initial begin
      int n;
      repeat (3) step(1'b1);
      run_until_fs();
      mode = 1; exp_und = 0;
      run_until_fs();
      run_until_fs();
      hold_arm = 1;
      run_until_fs();
      run_until_fs();
      n = 0;
      while (!(m_p % HT == 15 && (m_p / HT) % VT == 4) && n < 2 * FRAME) begin
         step(1'b0);
         n++;
      end
      step(1'b1);
      run_until_fs();
      mode = 2;
      repeat (6 * FRAME) step($urandom_range(0, 1999) == 0);
      repeat (2) step(1'b1);
      run_until_fs();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
